dir_hist_accum: RTL and testbench

- Builds the 16-bin gradient-orientation histogram for one keypoint window from a stream of (direction bin, magnitude) samples.
- Emits the packed histogram with a one-cycle valid pulse to the downstream main-orientation argmax stage.
- Sits between the gradient/orientation quantiser and the argmax stage.
- Accumulates with no stall: a new window may start on the cycle immediately after the previous window closes.

---
 rtl/dir_hist_accum.sv | 119 +++++++++++
 tb/tb_dir_hist_accum.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dir_hist_accum.sv
// 16-bin gradient-orientation histogram accumulator with saturating bins and a
// one-pulse packed output. Optional circular [1 2 1]/4 smoothing via HIST_SMOOTH_EN.
module dir_hist_accum #(
  parameter int CNT_DW = 16,
  parameter int MAG_DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [3:0]            sample_dir,
  input  logic [MAG_DW-1:0]     sample_mag,
  input  logic                  sample_last,
  output logic                  valid_out,
  output logic [16*CNT_DW-1:0]  dir_hist,
  output logic                  sat_flag
);

  localparam int NBIN = 16;

  logic [CNT_DW-1:0]      acc [NBIN];
  logic                   sat_trk;
  logic [CNT_DW:0]        sum;
  logic [CNT_DW-1:0]      upd;
  logic                   sat_ev;
  logic                   close;
  logic [NBIN*CNT_DW-1:0] hist_nxt;

  // One adder serves the addressed bin; the carry out is the saturation event.
  always_comb begin
    sum    = {1'b0, acc[sample_dir]} + (CNT_DW+1)'(sample_mag);
    upd    = sum[CNT_DW] ? '1 : sum[CNT_DW-1:0];
    sat_ev = sample_valid & sum[CNT_DW];
    close  = sample_valid & sample_last;
  end

  // Histogram as it stands after this edge's sample, used at close.
  always_comb begin
    hist_nxt = '0;
    for (int unsigned k = 0; k < NBIN; k++) begin
      hist_nxt[k*CNT_DW +: CNT_DW] = (4'(k) == sample_dir) ? upd : acc[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NBIN; k++) acc[k] <= '0;
      sat_trk <= 1'b0;
    end else if (close) begin
      for (int unsigned k = 0; k < NBIN; k++) acc[k] <= '0;
      sat_trk <= 1'b0;
    end else if (sample_valid) begin
      acc[sample_dir] <= upd;
      if (sat_ev) sat_trk <= 1'b1;
    end
  end

`ifdef HIST_SMOOTH_EN
  logic [NBIN*CNT_DW-1:0] s1_hist;
  logic                   s1_valid;
  logic                   s1_sat;
  logic [NBIN*CNT_DW-1:0] smooth;
  logic [CNT_DW+1:0]      ssum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_hist  <= '0;
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= close;
      if (close) begin
        s1_hist <= hist_nxt;
        s1_sat  <= sat_trk | sat_ev;
      end
    end
  end

  // Sum of 4 weights fits in CNT_DW+2 bits, so >>2 always fits back in CNT_DW.
  always_comb begin
    smooth = '0;
    ssum   = '0;
    for (int unsigned k = 0; k < NBIN; k++) begin
      ssum = {2'b00, s1_hist[((k + NBIN - 1) % NBIN)*CNT_DW +: CNT_DW]}
           + {1'b0, s1_hist[k*CNT_DW +: CNT_DW], 1'b0}
           + {2'b00, s1_hist[((k + 1) % NBIN)*CNT_DW +: CNT_DW]};
      smooth[k*CNT_DW +: CNT_DW] = ssum[CNT_DW+1:2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      dir_hist  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        dir_hist <= smooth;
        sat_flag <= s1_sat;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      dir_hist  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      valid_out <= close;
      if (close) begin
        dir_hist <= hist_nxt;
        sat_flag <= sat_trk | sat_ev;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dir_hist_accum.sv
// Directed self-checking bench for dir_hist_accum (CNT_DW=16, MAG_DW=8).
module tb_dir_hist_accum;

  localparam int CNT_DW = 16;
  localparam int MAG_DW = 8;
  localparam int HW     = 16*CNT_DW;

  logic              clk;
  logic              rst;
  logic              sample_valid;
  logic [3:0]        sample_dir;
  logic [MAG_DW-1:0] sample_mag;
  logic              sample_last;
  logic              valid_out;
  logic [HW-1:0]     dir_hist;
  logic              sat_flag;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  logic [HW-1:0] exp_h;

  dir_hist_accum #(.CNT_DW(CNT_DW), .MAG_DW(MAG_DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_dir   (sample_dir),
    .sample_mag   (sample_mag),
    .sample_last  (sample_last),
    .valid_out    (valid_out),
    .dir_hist     (dir_hist),
    .sat_flag     (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (valid_out === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic [MAG_DW-1:0] m, input logic l);
    sample_valid = 1'b1;
    sample_dir   = d;
    sample_mag   = m;
    sample_last  = l;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    sample_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    sample_last  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [HW-1:0] one_bin(input int k, input logic [CNT_DW-1:0] v);
    logic [HW-1:0] h;
    h = '0;
    h[k*CNT_DW +: CNT_DW] = v;
    return h;
  endfunction

  initial begin
    int p0;
    rst = 1'b0;
    sample_valid = 1'b0;
    sample_dir = '0;
    sample_mag = '0;
    sample_last = 1'b0;
    idle(2);
    chk("rst_valid", HW'(valid_out), '0);
    chk("rst_hist", dir_hist, '0);
    chk("rst_sat", HW'(sat_flag), '0);
    rst = 1'b1;
    idle(1);

`ifdef HIST_SMOOTH_EN
    p0 = pulses;
    send(4'd0, 8'd40, 1'b1);
    chk("sm_lat1_valid", HW'(valid_out), '0);
    idle(1);
    chk("sm_lat2_valid", HW'(valid_out), 1);
    exp_h = one_bin(15, 16'd10) | one_bin(0, 16'd20) | one_bin(1, 16'd10);
    chk("sm_hist", dir_hist, exp_h);
    chk("sm_sat", HW'(sat_flag), '0);
    idle(2);
    chk("sm_pulses", HW'(pulses - p0), 1);
    chk("sm_hold", dir_hist, exp_h);
`else
    // Close one window so outputs are non-zero, then reset mid-window.
    send(4'd7, 8'd3, 1'b1);
    chk("pre_hist", dir_hist, one_bin(7, 16'd3));
    send(4'd1, 8'd9, 1'b0);
    send(4'd0, 8'd9, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_hist", dir_hist, '0);
    idle(3);
    chk("mrst_valid", HW'(valid_out), '0);
    chk("mrst_hist", dir_hist, '0);
    chk("mrst_sat", HW'(sat_flag), '0);
    rst = 1'b1;
    idle(1);
    send(4'd0, 8'd1, 1'b1);
    chk("post_rst_valid", HW'(valid_out), 1);
    chk("post_rst_hist", dir_hist, one_bin(0, 16'd1));

    // Basic window on bin 5.
    idle(1);
    chk("idle_valid_low", HW'(valid_out), '0);
    p0 = pulses;
    send(4'd5, 8'd10, 1'b0);
    send(4'd5, 8'd20, 1'b0);
    chk("basic_no_early", HW'(valid_out), '0);
    send(4'd5, 8'd30, 1'b1);
    chk("basic_valid", HW'(valid_out), 1);
    chk("basic_hist", dir_hist, one_bin(5, 16'd60));
    chk("basic_sat", HW'(sat_flag), '0);
    idle(3);
    chk("basic_pulses", HW'(pulses - p0), 1);
    chk("basic_hold", dir_hist, one_bin(5, 16'd60));

    // Mixed bins with idle gaps; a stray last without valid is ignored.
    p0 = pulses;
    send(4'd3, 8'd100, 1'b0);
    idle(1);
    send(4'd15, 8'd7, 1'b0);
    send(4'd3, 8'd5, 1'b0);
    sample_last = 1'b1;
    sample_dir  = 4'd6;
    sample_mag  = 8'd99;
    @(posedge clk); #1;
    sample_last = 1'b0;
    send(4'd15, 8'd1, 1'b1);
    exp_h = one_bin(3, 16'd105) | one_bin(15, 16'd8);
    chk("mixed_hist", dir_hist, exp_h);
    idle(2);
    chk("mixed_pulses", HW'(pulses - p0), 1);

    // Back-to-back windows.
    p0 = pulses;
    send(4'd2, 8'd20, 1'b0);
    send(4'd2, 8'd30, 1'b1);
    chk("b2b_a_valid", HW'(valid_out), 1);
    chk("b2b_a_hist", dir_hist, one_bin(2, 16'd50));
    send(4'd9, 8'd7, 1'b1);
    chk("b2b_b_valid", HW'(valid_out), 1);
    chk("b2b_b_hist", dir_hist, one_bin(9, 16'd7));
    idle(1);
    chk("b2b_end_valid", HW'(valid_out), '0);
    chk("b2b_pulses", HW'(pulses - p0), 2);

    // Saturation: 259 * 255 far exceeds 65535.
    p0 = pulses;
    for (int i = 0; i < 258; i++) send(4'd4, 8'd255, 1'b0);
    chk("sat_no_pulse", HW'(pulses - p0), '0);
    send(4'd4, 8'd255, 1'b1);
    chk("sat_hist", dir_hist, one_bin(4, 16'hFFFF));
    chk("sat_flag", HW'(sat_flag), 1);
    send(4'd4, 8'd1, 1'b1);
    chk("sat_next_hist", dir_hist, one_bin(4, 16'd1));
    chk("sat_next_flag", HW'(sat_flag), '0);
    idle(1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
